// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm
// Purpose  : Serial receive state machine for the UART controller. It samples
//            RXD with a 16x oversampling enable and deframes 1 start bit,
//            8 data bits (LSB first), 1 even-parity bit and 2 stop bits. Each
//            received byte is presented with a valid/acknowledge handshake
//            and per-frame parity, framing and overrun flags.
// Ports    : CLK      in   system clock, rising edge
//            RST_N    in   asynchronous active-low reset
//            RX_CE    in   one-CLK pulse at 16x baud rate
//            RXD      in   asynchronous serial line, idle high
//            RX_ACK   in   host acknowledge (pulse or level)
//            RX_DATA  out  [7:0] received byte
//            RX_VLD   out  byte available, held until acknowledged
//            PAR_ERR  out  parity mismatch for RX_DATA
//            FRM_ERR  out  stop bit 1 or 2 sampled low for RX_DATA
//            OVR_ERR  out  byte completed while RX_VLD set; sticky to ACK
//            RX_BUSY  out  high in every state except IDLE
// Options  : UART_RX_MAJORITY_EN - 2-of-3 vote over ticks 7/8/9, decision at
//            tick 9. Undefined: single sample at tick 8.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_CE,
  input  logic       RXD,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_VLD,
  output logic       PAR_ERR,
  output logic       FRM_ERR,
  output logic       OVR_ERR,
  output logic       RX_BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PARB  = 3'd3,
    ST_STB1  = 3'd4,
    ST_STB2  = 3'd5
  } state_t;

  // The tick counter is compared before its increment, so the RX_CE that
  // brings the counter to tick N is the one seen while r_tick == N-1.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] c_SAMP_TICK = 4'd8;   // decision at tick 9
`else
  localparam logic [3:0] c_SAMP_TICK = 4'd7;   // single sample at tick 8
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rxd_meta;
  logic        r_rxd_s;
  logic [3:0]  r_tick;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_stop1;
  logic [7:0]  r_rx_data;
  logic        r_rx_vld;
  logic        r_par_err;
  logic        r_frm_err;
  logic        r_ovr_err;

  logic        w_bit;
  logic        w_samp;
  logic        w_wrap;
  logic        w_tick_clr;
  logic        w_bit_clr;
  logic        w_bit_inc;
  logic        w_shift;
  logic        w_cap_par;
  logic        w_cap_stb1;
  logic        w_done;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; flops reset to the idle line level.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Bit value at the sample point.
  // --------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  logic r_vote7;
  logic r_vote8;

  // Captures at ticks 7 and 8; the third vote is the live sample at tick 9.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vote7 <= 1'b1;
      r_vote8 <= 1'b1;
    end else if (RX_CE) begin
      if (r_tick == 4'd6) r_vote7 <= r_rxd_s;
      if (r_tick == 4'd7) r_vote8 <= r_rxd_s;
    end
  end

  assign w_bit = (r_vote7 & r_vote8) | (r_vote7 & r_rxd_s) | (r_vote8 & r_rxd_s);
`else
  assign w_bit = r_rxd_s;
`endif

  assign w_samp = RX_CE && (r_tick == c_SAMP_TICK);
  assign w_wrap = RX_CE && (r_tick == 4'hF);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_shift     = 1'b0;
    w_cap_par   = 1'b0;
    w_cap_stb1  = 1'b0;
    w_done      = 1'b0;
    RX_BUSY     = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (RX_CE && !r_rxd_s) begin
          w_state_nxt = ST_START;
          w_tick_clr  = 1'b1;
          w_bit_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (w_samp && w_bit) begin
          w_state_nxt = ST_IDLE;       // false start: glitch on the line
          w_tick_clr  = 1'b1;
        end else if (w_wrap) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_shift = w_samp;
        if (w_wrap) begin
          w_bit_inc = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARB;
        end
      end
      ST_PARB: begin
        w_cap_par = w_samp;
        if (w_wrap) w_state_nxt = ST_STB1;
      end
      ST_STB1: begin
        w_cap_stb1 = w_samp;
        if (w_wrap) w_state_nxt = ST_STB2;
      end
      ST_STB2: begin
        // Complete at the sample point so the next start edge can be caught
        // during the second half of the final stop bit.
        if (w_samp) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
          w_tick_clr  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tick_clr  = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive datapath: tick/bit counters and sample captures
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick    <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_stop1   <= 1'b0;
    end else begin
      if (w_tick_clr)  r_tick <= 4'd0;
      else if (RX_CE)  r_tick <= r_tick + 4'd1;

      if (w_bit_clr)      r_bit_cnt <= 3'd0;
      else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;

      // LSB arrives first, so shifting in from the MSB side leaves it at bit 0.
      if (w_shift)    r_shift <= {w_bit, r_shift[7:1]};
      if (w_cap_par)  r_par   <= w_bit;
      if (w_cap_stb1) r_stop1 <= w_bit;
    end
  end

  // --------------------------------------------------------------------------
  // Host-side holding register and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_data <= 8'h00;
      r_rx_vld  <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else if (w_done) begin
      r_rx_data <= r_shift;
      r_par_err <= (^r_shift) ^ r_par;
      r_frm_err <= ~r_stop1 | ~w_bit;
      r_rx_vld  <= 1'b1;
      // An ACK in the completion cycle consumes the old byte, so no overrun.
      if (RX_ACK)        r_ovr_err <= 1'b0;
      else if (r_rx_vld) r_ovr_err <= 1'b1;
    end else if (RX_ACK && r_rx_vld) begin
      r_rx_vld  <= 1'b0;
      r_ovr_err <= 1'b0;
    end
  end

  assign RX_DATA = r_rx_data;
  assign RX_VLD  = r_rx_vld;
  assign PAR_ERR = r_par_err;
  assign FRM_ERR = r_frm_err;
  assign OVR_ERR = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fsm
// Purpose  : Self-checking bench for uart_rx_fsm. Frames are driven at 16
//            RX_CE per bit (one RX_CE every 4 CLK); the expected byte and
//            flags of each frame are queued when the frame is sent and
//            compared once the frame has been received.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

  // RX_CE index within the stop-bit-2 period at which the frame completes:
  // start detection lands on the 2nd RX_CE of the start bit (synchronizer
  // latency), and the sample point is 8 (or 9) RX_CE later.
`ifdef UART_RX_MAJORITY_EN
  localparam int C_DONE = 10;
`else
  localparam int C_DONE = 9;
`endif

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b0;
  logic       RX_CE  = 1'b0;
  logic       RXD    = 1'b1;
  logic       RX_ACK = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_VLD;
  logic       PAR_ERR;
  logic       FRM_ERR;
  logic       OVR_ERR;
  logic       RX_BUSY;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       vld;
    logic       par;
    logic       frm;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  uart_rx_fsm dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RX_CE   (RX_CE),
    .RXD     (RXD),
    .RX_ACK  (RX_ACK),
    .RX_DATA (RX_DATA),
    .RX_VLD  (RX_VLD),
    .PAR_ERR (PAR_ERR),
    .FRM_ERR (FRM_ERR),
    .OVR_ERR (OVR_ERR),
    .RX_BUSY (RX_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One RX_CE pulse, then 3 idle CLKs; called and returns at a negedge.
  task automatic tick();
    RX_CE = 1'b1;
    @(negedge CLK);
    RX_CE  = 1'b0;
    RX_ACK = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic ack();
    RX_ACK = 1'b1;
    @(negedge CLK);
    RX_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, RX_DATA, e.data);
      chk({tag, "_vld"},  RX_VLD,  e.vld);
      chk({tag, "_par"},  PAR_ERR, e.par);
      chk({tag, "_frm"},  FRM_ERR, e.frm);
      chk({tag, "_ovr"},  OVR_ERR, e.ovr);
    end
  endtask

  // ack_idx: RX_CE index in stop bit 2 at which RX_ACK is raised (-1: none).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic p,
                            input logic s1, input logic s2, input int ack_idx,
                            input logic ovr_exp, input bit chk_lat);
    logic [11:0] bits;
    exp_t        e;
    bits   = {s2, s1, p, d, 1'b0};
    e.data = d;
    e.vld  = 1'b1;
    e.par  = (^d) ^ p;
    e.frm  = ~s1 | ~s2;
    e.ovr  = ovr_exp;
    sb.push_back(e);
    for (int b = 0; b < 12; b++) begin
      RXD = bits[b];
      for (int k = 0; k < 16; k++) begin
        if (b == 11 && k == ack_idx) RX_ACK = 1'b1;
        if (chk_lat && b == 11 && k == C_DONE) chk({tag, "_vld_before_done"}, RX_VLD, 1'b0);
        tick();
        if (chk_lat && b == 11 && k == C_DONE) chk({tag, "_vld_at_done"}, RX_VLD, 1'b1);
      end
    end
    RXD = 1'b1;
    repeat (20) tick();
    compare_head(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_data", RX_DATA, 8'h00);
    chk("rst_vld",  RX_VLD,  1'b0);
    chk("rst_par",  PAR_ERR, 1'b0);
    chk("rst_frm",  FRM_ERR, 1'b0);
    chk("rst_ovr",  OVR_ERR, 1'b0);
    chk("rst_busy", RX_BUSY, 1'b0);
    RST_N = 1'b1;
    repeat (4) tick();

    // Clean frame with latency check, then acknowledge
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1);
    ack();
    chk("a5_ack_vld",  RX_VLD,  1'b0);
    chk("a5_ack_data", RX_DATA, 8'hA5);

    // Parity error: 0x01 needs parity 1, sent 0
    send_frame("par", 8'h01, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    ack();

    // Framing error on stop bit 2
    send_frame("frm", 8'h3C, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    ack();
    chk("frm_ack_frm", FRM_ERR, 1'b1);

    // False start: 4 RX_CE low, then high
    RXD = 1'b0;
    repeat (4) tick();
    chk("fs_busy_high", RX_BUSY, 1'b1);
    RXD = 1'b1;
    repeat (20) tick();
    chk("fs_busy_low", RX_BUSY, 1'b0);
    chk("fs_vld",      RX_VLD,  1'b0);
    chk("fs_data",     RX_DATA, 8'h3C);

    // Overrun: two frames without ACK
    send_frame("ovr1", 8'h11, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    send_frame("ovr2", 8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0);
    ack();
    chk("ovr_ack_vld", RX_VLD,  1'b0);
    chk("ovr_ack_ovr", OVR_ERR, 1'b0);
    ack();  // ignored while RX_VLD is low
    chk("idle_ack_vld",  RX_VLD,  1'b0);
    chk("idle_ack_data", RX_DATA, 8'h22);

    // ACK landing in the completion cycle prevents overrun
    send_frame("ackc1", 8'h33, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    send_frame("ackc2", 8'h44, 1'b0, 1'b1, 1'b1, C_DONE, 1'b0, 1'b0);

    // Reset during data bit 4 of 0xFF (RX_VLD still set from 0x44)
    RXD = 1'b0;
    repeat (16) tick();
    RXD = 1'b1;
    repeat (16 * 4 + 8) tick();
    RST_N = 1'b0;
    #1;
    chk("mrst_data", RX_DATA, 8'h00);
    chk("mrst_vld",  RX_VLD,  1'b0);
    chk("mrst_ovr",  OVR_ERR, 1'b0);
    chk("mrst_busy", RX_BUSY, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) tick();
    chk("mrst_after_vld",  RX_VLD,  1'b0);
    chk("mrst_after_busy", RX_BUSY, 1'b0);

    send_frame("post", 8'h5A, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
